// File: rtl/dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_if
// Purpose : request/acknowledge bus between the MM-stage data-memory controller
//           and a variable-latency data memory.
// Signals :
//   dmem_req    controller -> memory  access request, held until ack/timeout
//   dmem_we     controller -> memory  1 = store, 0 = load
//   dmem_addr   controller -> memory  word-aligned byte address
//   dmem_be     controller -> memory  little-endian byte enables
//   dmem_wdata  controller -> memory  lane-replicated store data
//   dmem_rdata  memory -> controller  read data (valid with dmem_ack)
//   dmem_ack    memory -> controller  one-cycle completion strobe
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface dmem_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface : dmem_ctrl_if

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Purpose : sequences MM-stage loads/stores onto a req/ack data memory, holds
//           the pipeline (stall_req_o) until the access completes and returns
//           aligned, sign/zero-extended load data for the MM/WB register.
// Parameters:
//   TIMEOUT  cycles spent in BUSY before the access is abandoned (>= 2)
//   CNT_W    wait counter width, 2**CNT_W > TIMEOUT
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   dmem              dmem_ctrl_if.master, memory request/ack bus
//   mm_memread_i      MM-stage load (wins over mm_memwrite_i)
//   mm_memwrite_i     MM-stage store
//   mm_size_i         00 byte, 01 half, 10/11 word
//   mm_signext_i      1 = sign-extend load, 0 = zero-extend
//   mm_addr_i         byte address
//   mm_wdata_i        right-justified store data
//   mm_mmdata_o       registered load result
//   stall_req_o       combinational pipeline hold
//   bus_err_o         high for the DONE cycle after a timeout
//   align_err_o       (only with DMEM_ALIGN_CHECK_EN) high for the DONE cycle
//                     after a misaligned access
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   Defined   : misaligned half/word accesses skip the bus, go straight to
//               DONE, clear mm_mmdata_o and pulse align_err_o.
//   Undefined : no align_err_o port; low address bits below the access size
//               are ignored and the access proceeds normally.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.master dmem,
  input  logic        mm_memread_i,
  input  logic        mm_memwrite_i,
  input  logic [1:0]  mm_size_i,
  input  logic        mm_signext_i,
  input  logic [31:0] mm_addr_i,
  input  logic [31:0] mm_wdata_i,
  output logic [31:0] mm_mmdata_o,
  output logic        stall_req_o,
  output logic        bus_err_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        align_err_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Extracts the addressed lane from a read word and extends it to 32 bits.
  function automatic logic [31:0] load_extract(
    input logic [31:0] rd,
    input logic [1:0]  size,
    input logic [1:0]  lo,
    input logic        sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      2'b11:   b = rd[31:24];
      default: b = rd[7:0];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

`ifdef DMEM_ALIGN_CHECK_EN
  // True when the low address bits violate the natural alignment of the size.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = lo[0];
      default: m = (lo != 2'b00);
    endcase
    return m;
  endfunction
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      mm_mmdata_q;
  logic             bus_err_q;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  // Low address bits, size and extension mode of the access in flight; the
  // load result is formatted from these, not from the live MM-stage inputs.
  logic [1:0]       lo_q;
  logic [1:0]       size_q;
  logic             signext_q;
  logic             is_load_q;
`ifdef DMEM_ALIGN_CHECK_EN
  logic             align_err_q;
  logic             misaligned_s;
`endif

  logic             access_s;
  logic             stall_req_s;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d;

  assign access_s = mm_memread_i | mm_memwrite_i;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned_s = is_misaligned(mm_size_i, mm_addr_i[1:0]);
`endif

  // Byte enables and lane-replicated store data for the access being launched.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = mm_wdata_i;
    if (mm_memread_i) begin
      // Loads always fetch the whole word; lane selection happens on return.
      be_d    = 4'b1111;
      wdata_d = mm_wdata_i;
    end else begin
      case (mm_size_i)
        2'b00: begin
          be_d    = 4'b0001 << mm_addr_i[1:0];
          wdata_d = {4{mm_wdata_i[7:0]}};
        end
        2'b01: begin
          be_d    = mm_addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{mm_wdata_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = mm_wdata_i;
        end
      endcase
    end
  end

  // Pipeline hold: raised in the launch cycle and throughout BUSY, released in DONE.
  always_comb begin
    stall_req_s = 1'b0;
    case (state_q)
      ST_IDLE: stall_req_s = access_s;
      ST_BUSY: stall_req_s = 1'b1;
      ST_DONE: stall_req_s = 1'b0;
      default: stall_req_s = 1'b0;
    endcase
  end

  // Access sequencer: state, wait counter, bus outputs and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mm_mmdata_q <= 32'h0000_0000;
      bus_err_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      lo_q        <= 2'b00;
      size_q      <= 2'b00;
      signext_q   <= 1'b0;
      is_load_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_s) begin
`ifdef DMEM_ALIGN_CHECK_EN
            if (misaligned_s) begin
              // Never reaches the bus; report through align_err in DONE.
              mm_mmdata_q <= 32'h0000_0000;
              align_err_q <= 1'b1;
              state_q     <= ST_DONE;
            end else
`endif
            begin
              addr_q    <= {mm_addr_i[31:2], 2'b00};
              we_q      <= ~mm_memread_i;
              be_q      <= be_d;
              wdata_q   <= wdata_d;
              lo_q      <= mm_addr_i[1:0];
              size_q    <= mm_size_i;
              signext_q <= mm_signext_i;
              is_load_q <= mm_memread_i;
              req_q     <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ST_BUSY;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Ack is tested first so an ack in the final wait cycle still completes.
          if (dmem.dmem_ack) begin
            req_q <= 1'b0;
            if (is_load_q) begin
              mm_mmdata_q <= load_extract(dmem.dmem_rdata, size_q, lo_q, signext_q);
            end else begin
              mm_mmdata_q <= mm_mmdata_q;
            end
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            req_q       <= 1'b0;
            mm_mmdata_q <= 32'h0000_0000;
            bus_err_q   <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          bus_err_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
          align_err_q <= 1'b0;
`endif
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall_req_o      = stall_req_s;
  assign mm_mmdata_o      = mm_mmdata_q;
  assign bus_err_o        = bus_err_q;
  assign dmem.dmem_req    = req_q;
  assign dmem.dmem_we     = we_q;
  assign dmem.dmem_addr   = addr_q;
  assign dmem.dmem_be     = be_q;
  assign dmem.dmem_wdata  = wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err_o      = align_err_q;
`endif

endmodule : dmem_ctrl

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Purpose : directed self-checking bench for dmem_ctrl (TIMEOUT = 16).
//           Inputs change 1 ns after the rising edge; outputs are checked a
//           further 1 ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        mm_memread;
  logic        mm_memwrite;
  logic [1:0]  mm_size;
  logic        mm_signext;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_mmdata;
  logic        stall_req;
  logic        bus_err;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int errors = 0;
  int checks = 0;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem         (bus),
    .mm_memread_i (mm_memread),
    .mm_memwrite_i(mm_memwrite),
    .mm_size_i    (mm_size),
    .mm_signext_i (mm_signext),
    .mm_addr_i    (mm_addr),
    .mm_wdata_i   (mm_wdata),
    .mm_mmdata_o  (mm_mmdata),
    .stall_req_o  (stall_req),
    .bus_err_o    (bus_err)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .align_err_o  (align_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one access, acks it in BUSY cycle ack_lat, and returns in DONE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] size, input logic sx,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_lat,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    mm_memread  = rd;
    mm_memwrite = wr;
    mm_size     = size;
    mm_signext  = sx;
    mm_addr     = addr;
    mm_wdata    = wdata;
    #1;
    check({tag, ".stall_launch"}, stall_req, 32'd1);
    step();
    for (int c = 1; c <= ack_lat; c++) begin
      if (c == ack_lat) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end else begin
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h5555_5555;
      end
      #1;
      check({tag, ".stall_busy"}, stall_req, 32'd1);
      check({tag, ".req"}, bus.dmem_req, 32'd1);
      if (c == 1) begin
        check({tag, ".addr"}, bus.dmem_addr, addr & 32'hFFFF_FFFC);
        check({tag, ".be"}, bus.dmem_be, exp_be);
        check({tag, ".we"}, bus.dmem_we, wr & ~rd);
        if (wr & ~rd) begin
          check({tag, ".wdata"}, bus.dmem_wdata, exp_wdata);
        end
      end
      step();
    end
    bus.dmem_ack = 1'b0;
    mm_memread   = 1'b0;
    mm_memwrite  = 1'b0;
    #1;
    check({tag, ".stall_done"}, stall_req, 32'd0);
    check({tag, ".req_done"}, bus.dmem_req, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    mm_memread     = 1'b0;
    mm_memwrite    = 1'b0;
    mm_size        = 2'b00;
    mm_signext     = 1'b0;
    mm_addr        = 32'h0;
    mm_wdata       = 32'h0;
    bus.dmem_rdata = 32'h0;
    bus.dmem_ack   = 1'b0;

    // Reset state
    step();
    step();
    check("rst.mmdata", mm_mmdata, 32'h0);
    check("rst.bus_err", bus_err, 32'd0);
    check("rst.req", bus.dmem_req, 32'd0);
    check("rst.we", bus.dmem_we, 32'd0);
    check("rst.addr", bus.dmem_addr, 32'h0);
    check("rst.be", bus.dmem_be, 32'h0);
    check("rst.wdata", bus.dmem_wdata, 32'h0);
    check("rst.stall", stall_req, 32'd0);
    rst = 1'b0;
    step();
    check("idle.stall", stall_req, 32'd0);

    // Word load, ack in the third BUSY cycle
    access("wload", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,
           32'hDEAD_BEEF, 3, 4'b1111, 32'h0);
    check("wload.mmdata", mm_mmdata, 32'hDEAD_BEEF);
    check("wload.bus_err", bus_err, 32'd0);
    step();

    // Byte load lane 3, sign- then zero-extended
    access("bload_sx", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,
           32'h8012_3456, 1, 4'b1111, 32'h0);
    check("bload_sx.mmdata", mm_mmdata, 32'hFFFF_FF80);
    step();
    access("bload_zx", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,
           32'h8012_3456, 2, 4'b1111, 32'h0);
    check("bload_zx.mmdata", mm_mmdata, 32'h0000_0080);
    step();

    // Half load upper lane, sign-extended
    access("hload_sx", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,
           32'h8012_3456, 1, 4'b1111, 32'h0);
    check("hload_sx.mmdata", mm_mmdata, 32'hFFFF_8012);
    step();

    // Half store upper lane; load result must survive
    access("hstore", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD,
           32'h1111_1111, 2, 4'b1100, 32'hABCD_ABCD);
    check("hstore.mmdata", mm_mmdata, 32'hFFFF_8012);
    step();

    // Byte store lane 1
    access("bstore", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5677,
           32'h2222_2222, 1, 4'b0010, 32'h7777_7777);
    check("bstore.mmdata", mm_mmdata, 32'hFFFF_8012);
    step();

    // Half load lower lane, zero-extended
    access("hload_zx", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,
           32'h1234_F00D, 1, 4'b1111, 32'h0);
    check("hload_zx.mmdata", mm_mmdata, 32'h0000_F00D);
    step();

    // Timeout: no ack for 16 BUSY cycles
    mm_memread = 1'b1;
    mm_size    = 2'b10;
    mm_addr    = 32'h0000_0300;
    #1;
    check("tmo.stall_launch", stall_req, 32'd1);
    step();
    for (int c = 1; c <= 16; c++) begin
      check("tmo.req_busy", bus.dmem_req, 32'd1);
      check("tmo.stall_busy", stall_req, 32'd1);
      step();
    end
    mm_memread = 1'b0;
    #1;
    check("tmo.req_done", bus.dmem_req, 32'd0);
    check("tmo.bus_err", bus_err, 32'd1);
    check("tmo.mmdata", mm_mmdata, 32'h0);
    check("tmo.stall_done", stall_req, 32'd0);
    step();
    check("tmo.bus_err_clear", bus_err, 32'd0);
    check("tmo.stall_idle", stall_req, 32'd0);

    // Ack arriving in the timeout cycle wins
    access("ack_last", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,
           32'hCAFE_F00D, 16, 4'b1111, 32'h0);
    check("ack_last.mmdata", mm_mmdata, 32'hCAFE_F00D);
    check("ack_last.bus_err", bus_err, 32'd0);
    step();

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned word load never reaches the bus
    mm_memread = 1'b1;
    mm_size    = 2'b10;
    mm_addr    = 32'h0000_0106;
    #1;
    check("align.stall_launch", stall_req, 32'd1);
    step();
    mm_memread = 1'b0;
    #1;
    check("align.req", bus.dmem_req, 32'd0);
    check("align.align_err", align_err, 32'd1);
    check("align.mmdata", mm_mmdata, 32'h0);
    check("align.stall_done", stall_req, 32'd0);
    step();
    check("align.align_err_clear", align_err, 32'd0);
    check("align.req_idle", bus.dmem_req, 32'd0);
`endif

    // Reset in the second BUSY cycle, then a late ack
    mm_memread = 1'b1;
    mm_size    = 2'b10;
    mm_addr    = 32'h0000_0500;
    step();
    check("rstmid.req_busy1", bus.dmem_req, 32'd1);
    step();
    rst        = 1'b1;
    mm_memread = 1'b0;
    #1;
    check("rstmid.req", bus.dmem_req, 32'd0);
    check("rstmid.stall", stall_req, 32'd0);
    check("rstmid.mmdata", mm_mmdata, 32'h0);
    step();
    rst            = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h1234_5678;
    step();
    bus.dmem_ack = 1'b0;
    #1;
    check("rstmid.late_req", bus.dmem_req, 32'd0);
    check("rstmid.late_stall", stall_req, 32'd0);
    check("rstmid.late_bus_err", bus_err, 32'd0);
    check("rstmid.late_mmdata", mm_mmdata, 32'h0);
    step();
    check("rstmid.idle_mmdata", mm_mmdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dmem_ctrl
